axi_lite_pt_loopback: RTL and testbench
=======================================

// Module: axi_lite_pt_loopback
// PURPOSE
//   Self-contained AXI4-Lite loopback: a runtime traffic master drives a passthrough monitor slot feeding a
//   register-memory slave, with a built-in scoreboard. Serves as the synthesizable core of the master ->
//   passthrough -> slave example system; it exposes only clock, reset and status.
// PARAMETERS
//   NUM_TXN    16            number of write transactions, then the same number of read transactions
//   DATA_W     32            AXI data width; WSTRB is all ones
//   ADDR_W     8             AXI address width; byte address, word index = addr[ADDR_W-1:2]
//   MEM_DEPTH  16            slave words; an index >= MEM_DEPTH is out of range
//   DATA_SEED  32'hA5A5_0000 write data for transaction i = DATA_SEED + i
// PORTS
//   aclk         in   1       clock, rising edge
//   aresetn      in   1       asynchronous reset, ACTIVE-HIGH (codebase port name kept); 1 = in reset
//   corrupt      in   1       when 1, slave flips RDATA[0] on read beats (scoreboard error injection)
//   done         out  1       all NUM_TXN writes and reads completed; sticky until reset
//   pass         out  1       done && mismatch_cnt==0 && resp_err_cnt==0
//   wr_cnt       out  16      B-channel handshakes seen by passthrough monitor
//   rd_cnt       out  16      R-channel handshakes seen by passthrough monitor
//   mismatch_cnt out  16      read beats whose RDATA != scoreboard expected value
//   resp_err_cnt out  16      B/R beats with RESP != OKAY
// BEHAVIOUR
//   - Reset (async assert, sync release): master FSM in IDLE, all VALID/READY low, slave memory cleared to 0,
//     all counters 0, done=0, pass=0.
//   - Master FSM: IDLE -> WR_ADDR -> WR_RESP -> ... -> RD_ADDR -> RD_DATA -> ... -> DONE.
//     IDLE lasts exactly one cycle after reset release. Transaction i uses address i*4.
//   - WR_ADDR: assert AWVALID and WVALID together. Each holds VALID until its own handshake
//     (VALID && READY on a rising edge). Go to WR_RESP when both have completed.
//   - WR_RESP: BREADY=1; on the B handshake, i++. Go to RD_ADDR with i=0 when i reaches NUM_TXN.
//   - RD_ADDR: ARVALID until handshake. RD_DATA: RREADY=1; on the R handshake, i++.
//     Go to DONE when i reaches NUM_TXN.
//   - DONE is terminal; done=1, and pass is evaluated combinationally from the counters.
//   - Only one transaction is outstanding at a time; no reordering. VALID is never dropped before its handshake.
//   - Slave, write path:
//       * AWREADY/WREADY assert the cycle after the corresponding VALID is seen (1-cycle latency).
//       * Address and data are captured independently.
//       * BVALID rises the cycle after both are captured and holds until BREADY.
//       * In range: memory written, BRESP=OKAY(2'b00). Out of range: no write, BRESP=SLVERR(2'b10).
//   - Slave, read path:
//       * ARREADY asserts the cycle after ARVALID.
//       * RVALID rises the next cycle, RDATA = mem[index] (0 if out of range), RRESP = OKAY or SLVERR.
//       * RDATA[0] is inverted while corrupt=1. RVALID holds until RREADY.
//   - Passthrough slot: wires master to slave unmodified (zero latency); monitors handshakes only.
//   - Scoreboard:
//       * Shadow array updated on each B handshake with OKAY.
//       * On each R handshake, compares RDATA with shadow[index] (0 if never written or out of range).
//       * Counters saturate at 16'hFFFF.
//   - Reset asserted mid-transaction aborts immediately. Everything returns to reset values, and the sequence
//     restarts from i=0 after release.
//   - NUM_TXN > MEM_DEPTH is legal. Extra writes get SLVERR, and their reads return 0 with SLVERR,
//     so pass=0 in that configuration.
// TESTING
//   - Hold aresetn=1 for 5 cycles, release, corrupt=0 -> done=1 within 8*NUM_TXN cycles; wr_cnt=16,
//     rd_cnt=16, mismatch_cnt=0, pass=1.
//   - Check the bus after reset: 1st AW address 8'h00 with WDATA=32'hA5A5_0000; last read
//     (addr 8'h3C) returns 32'hA5A5_000F.
//   - corrupt=1 for the whole run -> mismatch_cnt=16, resp_err_cnt=0, pass=0, done=1.
//   - NUM_TXN=20, MEM_DEPTH=16 -> resp_err_cnt=8 (4 B + 4 R SLVERR), mismatch_cnt=0, pass=0.
//   - Assert aresetn for 2 cycles during the 5th write -> counters clear; the rerun completes with pass=1
//     and wr_cnt=16.
//   - Protocol checks throughout: no VALID drops without a handshake, and at most one outstanding
//     transaction per direction.

Source files
------------

// File: rtl/axi_lite_pt_loopback.sv
// AXI4-Lite loopback core: a sequential traffic master, a zero-latency passthrough monitor slot and a
// register-memory slave, with a shadow-memory scoreboard reporting counters and a pass flag.
module axi_lite_pt_loopback #(
  parameter int unsigned       NUM_TXN   = 16,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 8,
  parameter int unsigned       MEM_DEPTH = 16,
  parameter logic [DATA_W-1:0] DATA_SEED = 32'hA5A5_0000
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        corrupt,
  output logic        done,
  output logic        pass,
  output logic [15:0] wr_cnt,
  output logic [15:0] rd_cnt,
  output logic [15:0] mismatch_cnt,
  output logic [15:0] resp_err_cnt
);
  localparam int unsigned IDX_W  = $clog2(NUM_TXN + 1);
  localparam int unsigned MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TXN - 1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_ADDR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_DONE
  } state_e;

  // Shared bus: the passthrough slot is pure wiring between master and slave; WSTRB is implicitly all ones.
  logic              awvalid, awready, wvalid, wready, bvalid, bready;
  logic              arvalid, arready, rvalid, rready;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [DATA_W-1:0] wdata, rdata;
  logic [1:0]        bresp, rresp;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a[ADDR_W-1:2]) < MEM_DEPTH;
  endfunction

  function automatic logic [MEM_AW-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return MEM_AW'(a[ADDR_W-1:2]);
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] c, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, c} + {15'b0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // ---------------- master ----------------
  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             aw_sent_q, aw_sent_d, w_sent_q, w_sent_d;

  assign awaddr = ADDR_W'({idx_q, 2'b00});
  assign araddr = awaddr;
  assign wdata  = DATA_SEED + DATA_W'(idx_q);

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can leave it unassigned (no latches).
    state_d   = state_q;
    idx_d     = idx_q;
    aw_sent_d = aw_sent_q;
    w_sent_d  = w_sent_q;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_WR_ADDR;
      S_WR_ADDR: begin
        awvalid = !aw_sent_q;
        wvalid  = !w_sent_q;
        if (awvalid && awready) aw_sent_d = 1'b1;
        if (wvalid && wready)   w_sent_d  = 1'b1;
        if (aw_sent_d && w_sent_d) begin
          aw_sent_d = 1'b0;
          w_sent_d  = 1'b0;
          state_d   = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        bready = 1'b1;
        if (bvalid) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = S_RD_ADDR;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_WR_ADDR;
          end
        end
      end
      S_RD_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        rready = 1'b1;
        if (rvalid) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_RD_ADDR;
          end
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- slave ----------------
  logic              awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
  logic              aw_cap_q, aw_cap_d, w_cap_q, w_cap_d;
  logic [ADDR_W-1:0] s_awaddr_q, s_awaddr_d, wr_addr;
  logic [DATA_W-1:0] s_wdata_q, s_wdata_d, wr_data;
  logic              bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic [DATA_W-1:0] mem_d [MEM_DEPTH];

  assign awready = awready_q;
  assign wready  = wready_q;
  assign arready = arready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign rvalid  = rvalid_q;
  assign rresp   = rresp_q;
  assign rdata   = rdata_q ^ {{(DATA_W-1){1'b0}}, corrupt};

  always_comb begin
    awready_d  = awvalid && !awready_q && !aw_cap_q && !bvalid_q;
    wready_d   = wvalid && !wready_q && !w_cap_q && !bvalid_q;
    arready_d  = arvalid && !arready_q && !rvalid_q;
    aw_cap_d   = aw_cap_q;
    w_cap_d    = w_cap_q;
    s_awaddr_d = s_awaddr_q;
    s_wdata_d  = s_wdata_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;
    mem_d      = mem_q;
    if (awvalid && awready_q) begin
      aw_cap_d   = 1'b1;
      s_awaddr_d = awaddr;
    end
    if (wvalid && wready_q) begin
      w_cap_d   = 1'b1;
      s_wdata_d = wdata;
    end
    // A handshake in this cycle counts as captured, so B can launch on the same edge.
    wr_addr = (awvalid && awready_q) ? awaddr : s_awaddr_q;
    wr_data = (wvalid && wready_q) ? wdata : s_wdata_q;
    if (bvalid_q && bready) bvalid_d = 1'b0;
    if (aw_cap_d && w_cap_d && !bvalid_q) begin
      aw_cap_d = 1'b0;
      w_cap_d  = 1'b0;
      bvalid_d = 1'b1;
      if (in_range(wr_addr)) begin
        mem_d[word_idx(wr_addr)] = wr_data;
        bresp_d = RESP_OKAY;
      end else begin
        bresp_d = RESP_SLVERR;
      end
    end
    if (rvalid_q && rready) rvalid_d = 1'b0;
    if (arvalid && arready_q) begin
      rvalid_d = 1'b1;
      rdata_d  = in_range(araddr) ? mem_q[word_idx(araddr)] : '0;
      rresp_d  = in_range(araddr) ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // ---------------- passthrough monitor + scoreboard ----------------
  logic [ADDR_W-1:0] mon_awaddr_q, mon_awaddr_d, mon_araddr_q, mon_araddr_d;
  logic [DATA_W-1:0] mon_wdata_q, mon_wdata_d, exp_rdata;
  logic [DATA_W-1:0] shadow_q [MEM_DEPTH];
  logic [DATA_W-1:0] shadow_d [MEM_DEPTH];
  logic [15:0]       wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [15:0]       mis_cnt_q, mis_cnt_d, err_cnt_q, err_cnt_d;
  logic              b_hs, r_hs, b_err, r_err, r_mis;

  always_comb begin
    b_hs         = bvalid && bready;
    r_hs         = rvalid && rready;
    b_err        = b_hs && (bresp != RESP_OKAY);
    r_err        = r_hs && (rresp != RESP_OKAY);
    mon_awaddr_d = (awvalid && awready) ? awaddr : mon_awaddr_q;
    mon_wdata_d  = (wvalid && wready) ? wdata : mon_wdata_q;
    mon_araddr_d = (arvalid && arready) ? araddr : mon_araddr_q;
    shadow_d     = shadow_q;
    if (b_hs && !b_err && in_range(mon_awaddr_q)) shadow_d[word_idx(mon_awaddr_q)] = mon_wdata_q;
    exp_rdata    = in_range(mon_araddr_q) ? shadow_q[word_idx(mon_araddr_q)] : '0;
    r_mis        = r_hs && (rdata != exp_rdata);
    wr_cnt_d     = sat_add(wr_cnt_q, {1'b0, b_hs});
    rd_cnt_d     = sat_add(rd_cnt_q, {1'b0, r_hs});
    mis_cnt_d    = sat_add(mis_cnt_q, {1'b0, r_mis});
    err_cnt_d    = sat_add(err_cnt_q, {1'b0, b_err} + {1'b0, r_err});
  end

  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      aw_sent_q    <= 1'b0;
      w_sent_q     <= 1'b0;
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      arready_q    <= 1'b0;
      aw_cap_q     <= 1'b0;
      w_cap_q      <= 1'b0;
      s_awaddr_q   <= '0;
      s_wdata_q    <= '0;
      bvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      rvalid_q     <= 1'b0;
      rresp_q      <= RESP_OKAY;
      rdata_q      <= '0;
      // NOTE: the memories are small flop arrays cleared by reset, which rules out inferring a RAM macro.
      mem_q        <= '{default: '0};
      shadow_q     <= '{default: '0};
      mon_awaddr_q <= '0;
      mon_wdata_q  <= '0;
      mon_araddr_q <= '0;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      mis_cnt_q    <= '0;
      err_cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking here so every flop samples pre-edge values; blocking is only for always_comb.
      state_q      <= state_d;
      idx_q        <= idx_d;
      aw_sent_q    <= aw_sent_d;
      w_sent_q     <= w_sent_d;
      awready_q    <= awready_d;
      wready_q     <= wready_d;
      arready_q    <= arready_d;
      aw_cap_q     <= aw_cap_d;
      w_cap_q      <= w_cap_d;
      s_awaddr_q   <= s_awaddr_d;
      s_wdata_q    <= s_wdata_d;
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      rvalid_q     <= rvalid_d;
      rresp_q      <= rresp_d;
      rdata_q      <= rdata_d;
      mem_q        <= mem_d;
      shadow_q     <= shadow_d;
      mon_awaddr_q <= mon_awaddr_d;
      mon_wdata_q  <= mon_wdata_d;
      mon_araddr_q <= mon_araddr_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      mis_cnt_q    <= mis_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign done         = (state_q == S_DONE);
  assign pass         = done && (mis_cnt_q == 16'h0) && (err_cnt_q == 16'h0);
  assign wr_cnt       = wr_cnt_q;
  assign rd_cnt       = rd_cnt_q;
  assign mismatch_cnt = mis_cnt_q;
  assign resp_err_cnt = err_cnt_q;
endmodule

// File: tb/tb_axi_lite_pt_loopback.sv
// Scoreboard bench for axi_lite_pt_loopback: expected beats and final status are queued by the stimulus,
// and a negedge monitor pops and compares them as handshakes and done appear on the DUT.
module tb_axi_lite_pt_loopback;
  localparam int N   = 16;
  localparam int N20 = 20;

  logic        clk = 1'b0, rst = 1'b1, corrupt = 1'b0, rst20 = 1'b1, corrupt20 = 1'b0;
  logic        done, pass, done20, pass20;
  logic [15:0] wr_cnt, rd_cnt, mis_cnt, err_cnt;
  logic [15:0] wr_cnt20, rd_cnt20, mis_cnt20, err_cnt20;

  always #5 clk = ~clk;

  axi_lite_pt_loopback u_dut (
    .aclk(clk), .aresetn(rst), .corrupt(corrupt), .done(done), .pass(pass),
    .wr_cnt(wr_cnt), .rd_cnt(rd_cnt), .mismatch_cnt(mis_cnt), .resp_err_cnt(err_cnt)
  );

  axi_lite_pt_loopback #(.NUM_TXN(N20)) u_dut20 (
    .aclk(clk), .aresetn(rst20), .corrupt(corrupt20), .done(done20), .pass(pass20),
    .wr_cnt(wr_cnt20), .rd_cnt(rd_cnt20), .mismatch_cnt(mis_cnt20), .resp_err_cnt(err_cnt20)
  );

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
    logic [1:0]  resp;
  } beat_t;

  typedef struct packed {
    logic [15:0] wr;
    logic [15:0] rd;
    logic [15:0] mis;
    logic [15:0] err;
    logic        pass;
  } stat_t;

  beat_t wq[$], rq[$];
  stat_t sq[$], sq20[$];
  int    total = 0, bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s: handshake with no queued expectation", name);
  endtask

  // ---------------- monitor ----------------
  logic [7:0]  aw_a, ar_a;
  logic [31:0] w_d;
  int          aw_out, ar_out;
  logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_bv, p_br, p_rv, p_rr, done_p, done20_p;

  always @(negedge clk) begin
    beat_t e;
    stat_t s;
    if (rst) begin
      {p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_bv, p_br, p_rv, p_rr, done_p} = '0;
      aw_out = 0;
      ar_out = 0;
    end else begin
      if (p_awv && !p_awr) check("aw_valid_hold", u_dut.awvalid, 1);
      if (p_wv && !p_wr)   check("w_valid_hold", u_dut.wvalid, 1);
      if (p_arv && !p_arr) check("ar_valid_hold", u_dut.arvalid, 1);
      if (p_bv && !p_br)   check("b_valid_hold", u_dut.bvalid, 1);
      if (p_rv && !p_rr)   check("r_valid_hold", u_dut.rvalid, 1);
      if (u_dut.awvalid && u_dut.awready) begin
        check("aw_outstanding", aw_out, 0);
        aw_a   = u_dut.awaddr;
        aw_out = 1;
      end
      if (u_dut.wvalid && u_dut.wready) w_d = u_dut.wdata;
      if (u_dut.bvalid && u_dut.bready) begin
        if (wq.size() == 0) unexpected("b_beat");
        else begin
          e = wq.pop_front();
          check("wr_addr", aw_a, e.addr);
          check("wr_data", w_d, e.data);
          check("bresp", u_dut.bresp, e.resp);
        end
        aw_out = 0;
      end
      if (u_dut.arvalid && u_dut.arready) begin
        check("ar_outstanding", ar_out, 0);
        ar_a   = u_dut.araddr;
        ar_out = 1;
      end
      if (u_dut.rvalid && u_dut.rready) begin
        if (rq.size() == 0) unexpected("r_beat");
        else begin
          e = rq.pop_front();
          check("rd_addr", ar_a, e.addr);
          check("rd_data", u_dut.rdata, e.data);
          check("rresp", u_dut.rresp, e.resp);
        end
        ar_out = 0;
      end
      if (done && !done_p) begin
        if (sq.size() == 0) unexpected("done");
        else begin
          s = sq.pop_front();
          check("stat_wr_cnt", wr_cnt, s.wr);
          check("stat_rd_cnt", rd_cnt, s.rd);
          check("stat_mismatch", mis_cnt, s.mis);
          check("stat_resp_err", err_cnt, s.err);
          check("stat_pass", pass, s.pass);
        end
      end
      {p_awv, p_awr, p_wv, p_wr} = {u_dut.awvalid, u_dut.awready, u_dut.wvalid, u_dut.wready};
      {p_arv, p_arr, p_bv, p_br} = {u_dut.arvalid, u_dut.arready, u_dut.bvalid, u_dut.bready};
      {p_rv, p_rr, done_p}       = {u_dut.rvalid, u_dut.rready, done};
    end
  end

  always @(negedge clk) begin
    stat_t s;
    if (rst20) done20_p = 1'b0;
    else begin
      if (done20 && !done20_p) begin
        if (sq20.size() == 0) unexpected("done20");
        else begin
          s = sq20.pop_front();
          check("n20_wr_cnt", wr_cnt20, s.wr);
          check("n20_rd_cnt", rd_cnt20, s.rd);
          check("n20_mismatch", mis_cnt20, s.mis);
          check("n20_resp_err", err_cnt20, s.err);
          check("n20_pass", pass20, s.pass);
        end
      end
      done20_p = done20;
    end
  end

  // ---------------- stimulus ----------------
  task automatic clear_q();
    wq.delete();
    rq.delete();
    sq.delete();
  endtask

  task automatic push_run(input logic c);
    for (int i = 0; i < N; i++) begin
      wq.push_back('{addr: 8'(i * 4), data: 32'hA5A5_0000 + 32'(i), resp: 2'b00});
      rq.push_back('{addr: 8'(i * 4), data: (32'hA5A5_0000 + 32'(i)) ^ {31'b0, c}, resp: 2'b00});
    end
    sq.push_back('{wr: 16'd16, rd: 16'd16, mis: c ? 16'd16 : 16'd0, err: 16'd0, pass: !c});
  endtask

  task automatic reset_check(input string tag);
    @(negedge clk);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_counters"}, {wr_cnt, rd_cnt, mis_cnt, err_cnt}, 0);
    check({tag, "_valids"}, {u_dut.awvalid, u_dut.wvalid, u_dut.arvalid, u_dut.bvalid, u_dut.rvalid}, 0);
  endtask

  task automatic wait_done(input string tag);
    for (int n = 0; n < 8 * N && !done; n++) begin
      @(posedge clk);
      #1;
    end
    check({tag, "_done_in_budget"}, done, 1);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_queues_drained"}, wq.size() + rq.size() + sq.size(), 0);
  endtask

  initial begin
    // Run 1: clean, also checks the single IDLE cycle and the 20-transaction instance.
    clear_q();
    push_run(1'b0);
    sq20.push_back('{wr: 16'd20, rd: 16'd20, mis: 16'd0, err: 16'd8, pass: 1'b0});
    reset_check("rst1");
    repeat (4) @(posedge clk);
    #1;
    rst   = 1'b0;
    rst20 = 1'b0;
    @(negedge clk);
    check("idle_cycle_awvalid", u_dut.awvalid, 0);
    @(negedge clk);
    check("first_wr_addr_awvalid", u_dut.awvalid, 1);
    wait_done("clean");
    for (int n = 0; n < 8 * N20 && !done20; n++) @(posedge clk);
    #1;
    check("n20_done_in_budget", done20, 1);
    @(posedge clk);
    #1;
    check("n20_status_consumed", sq20.size(), 0);

    // Run 2: corruption for the whole run.
    rst     = 1'b1;
    corrupt = 1'b1;
    clear_q();
    push_run(1'b1);
    reset_check("rst2");
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    wait_done("corrupt");

    // Run 3: reset pulse in the middle of the 5th write, then a clean rerun.
    rst     = 1'b1;
    corrupt = 1'b0;
    clear_q();
    push_run(1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int n = 0; n < 100 && !(wr_cnt == 16'd4 && u_dut.awvalid); n++) begin
      @(posedge clk);
      #1;
    end
    check("reached_5th_write", {wr_cnt, 15'b0, u_dut.awvalid}, {16'd4, 16'd1});
    rst = 1'b1;
    clear_q();
    push_run(1'b0);
    reset_check("abort");
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_done("rerun");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
